// File: rtl/load_distributor.sv
// Load distributor: splits wide memory beats into per-lane VRF write operands,
// holding each lane's operand until that lane grants it.
module load_distributor #(
  parameter int NrLane    = 4,
  parameter int DataWidth = 64,
  parameter int AddrWidth = 10,
  parameter int IdWidth   = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [IdWidth-1:0]              cmd_id_i,
  input  logic [AddrWidth-1:0]            cmd_vaddr_i,
  input  logic [15:0]                     cmd_nbytes_i,
  input  logic                            mem_valid_i,
  output logic                            mem_ready_o,
  input  logic [NrLane*DataWidth-1:0]     mem_data_i,
  output logic [NrLane-1:0]               load_op_valid_o,
  input  logic [NrLane-1:0]               load_op_gnt_i,
  output logic [NrLane*DataWidth-1:0]     load_op_o,
  output logic [NrLane*DataWidth/8-1:0]   load_op_strb_o,
  output logic [NrLane*AddrWidth-1:0]     load_op_addr_o,
  output logic [NrLane*IdWidth-1:0]       load_id_o,
  output logic                            done_o,
  output logic [IdWidth-1:0]              done_id_o
);

  localparam int LaneBytes = DataWidth / 8;
  localparam int BeatBytes = NrLane * LaneBytes;
  localparam logic [15:0] BeatBytes16 = 16'(BeatBytes);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [15:0]            rem_q, rem_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic                   done_q, done_d;
  logic [IdWidth-1:0]     done_id_q, done_id_d;

  logic [NrLane-1:0]                  valid_q, valid_d;
  logic [NrLane-1:0][DataWidth-1:0]   data_q, data_d;
  logic [NrLane-1:0][LaneBytes-1:0]   strb_q, strb_d;
  logic [NrLane-1:0][AddrWidth-1:0]   laddr_q, laddr_d;
  logic [NrLane-1:0][IdWidth-1:0]     lid_q, lid_d;

  logic                               lanes_free;
  logic                               beat;
  logic [15:0]                        take;
  int                                 lane_bytes;
  logic [NrLane-1:0]                  beat_valid;
  logic [NrLane-1:0][LaneBytes-1:0]   beat_strb;
  logic [NrLane-1:0][DataWidth-1:0]   beat_data;

  // A lane is free when it holds nothing or is handing its operand over now.
  assign lanes_free  = &(~valid_q | load_op_gnt_i);
  assign mem_ready_o = (state_q == RUN) && lanes_free;
  assign beat        = mem_valid_i && mem_ready_o;
  assign beat_data   = mem_data_i;
  assign take        = (rem_q > BeatBytes16) ? BeatBytes16 : rem_q;

  // Bytes owned by each lane in the current beat, clamped to one lane slice.
  always_comb begin
    lane_bytes = 0;
    beat_valid = '0;
    beat_strb  = '0;
    for (int i = 0; i < NrLane; i++) begin
      lane_bytes = int'(rem_q) - i * LaneBytes;
      if (lane_bytes < 0)         lane_bytes = 0;
      if (lane_bytes > LaneBytes) lane_bytes = LaneBytes;
      beat_valid[i] = (lane_bytes != 0);
      for (int j = 0; j < LaneBytes; j++) begin
        beat_strb[i][j] = (j < lane_bytes);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    id_d      = id_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    valid_d   = valid_q & ~load_op_gnt_i;
    data_d    = data_q;
    strb_d    = strb_q;
    laddr_d   = laddr_q;
    lid_d     = lid_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          id_d   = cmd_id_i;
          addr_d = cmd_vaddr_i;
          rem_d  = cmd_nbytes_i;
          if (cmd_nbytes_i == 16'd0) begin
            done_d    = 1'b1;
            done_id_d = cmd_id_i;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (beat) begin
          for (int i = 0; i < NrLane; i++) begin
            valid_d[i] = beat_valid[i];
            data_d[i]  = beat_data[i];
            strb_d[i]  = beat_strb[i];
            laddr_d[i] = addr_q;
            lid_d[i]   = id_q;
          end
          addr_d = addr_q + AddrWidth'(1);
          rem_d  = rem_q - take;
          if (rem_q == take) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (lanes_free) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          done_id_d = id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      id_q      <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      valid_q   <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      laddr_q   <= '0;
      lid_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      id_q      <= id_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      laddr_q   <= laddr_d;
      lid_q     <= lid_d;
    end
  end

  assign cmd_ready_o     = (state_q == IDLE);
  assign load_op_valid_o = valid_q;
  assign load_op_o       = data_q;
  assign load_op_strb_o  = strb_q;
  assign load_op_addr_o  = laddr_q;
  assign load_id_o       = lid_q;
  assign done_o          = done_q;
  assign done_id_o       = done_id_q;

endmodule

// File: tb/tb_load_distributor.sv
// Directed bench for load_distributor: hand-computed expectations for each step,
// checked with immediate assertions.
module tb_load_distributor;

  logic         clk_i;
  logic         rst_i;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [2:0]   cmd_id_i;
  logic [9:0]   cmd_vaddr_i;
  logic [15:0]  cmd_nbytes_i;
  logic         mem_valid_i;
  logic         mem_ready_o;
  logic [255:0] mem_data_i;
  logic [3:0]   load_op_valid_o;
  logic [3:0]   load_op_gnt_i;
  logic [255:0] load_op_o;
  logic [31:0]  load_op_strb_o;
  logic [39:0]  load_op_addr_o;
  logic [11:0]  load_id_o;
  logic         done_o;
  logic [2:0]   done_id_o;

  int n_checks = 0;
  int n_fails  = 0;

  load_distributor dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_id_i        (cmd_id_i),
    .cmd_vaddr_i     (cmd_vaddr_i),
    .cmd_nbytes_i    (cmd_nbytes_i),
    .mem_valid_i     (mem_valid_i),
    .mem_ready_o     (mem_ready_o),
    .mem_data_i      (mem_data_i),
    .load_op_valid_o (load_op_valid_o),
    .load_op_gnt_i   (load_op_gnt_i),
    .load_op_o       (load_op_o),
    .load_op_strb_o  (load_op_strb_o),
    .load_op_addr_o  (load_op_addr_o),
    .load_id_o       (load_id_o),
    .done_o          (done_o),
    .done_id_o       (done_id_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Beat pattern: lane i carries base + i.
  function automatic logic [255:0] mk(input logic [63:0] base);
    logic [255:0] r;
    for (int i = 0; i < 4; i++) r[i*64 +: 64] = base + 64'(i);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic mv, input logic [255:0] md, input logic [3:0] gnt);
    mem_valid_i   = mv;
    mem_data_i    = md;
    load_op_gnt_i = gnt;
    #1;
  endtask

  task automatic issueCmd(input logic [2:0] id, input logic [9:0] vaddr, input logic [15:0] nbytes);
    cmd_valid_i  = 1'b1;
    cmd_id_i     = id;
    cmd_vaddr_i  = vaddr;
    cmd_nbytes_i = nbytes;
    #1;
  endtask

  task automatic nextCycle;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_id_i = '0; cmd_vaddr_i = '0; cmd_nbytes_i = '0;
    mem_valid_i = 1'b0; mem_data_i = '0; load_op_gnt_i = '0;
    nextCycle;
    nextCycle;

    // Reset state
    checkOutput("rst_cmd_ready", cmd_ready_o, 1);
    checkOutput("rst_valid", load_op_valid_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_done_id", done_id_o, 0);
    checkOutput("rst_data", load_op_o, 0);
    checkOutput("rst_strb", load_op_strb_o, 0);
    checkOutput("rst_addr", load_op_addr_o, 0);
    checkOutput("rst_mem_ready", mem_ready_o, 0);
    rst_i = 1'b0;
    nextCycle;
    checkOutput("post_rst_cmd_ready", cmd_ready_o, 1);

    // 64 bytes, vaddr 5, id 2: two full beats, grants always high
    $display("[TB] two full beats");
    issueCmd(3'd2, 10'd5, 16'd64);
    applyStimulus(1'b0, '0, 4'hF);
    nextCycle;
    cmd_valid_i = 1'b0;
    checkOutput("t1_cmd_ready_run", cmd_ready_o, 0);
    applyStimulus(1'b1, mk(64'hA0), 4'hF);
    checkOutput("t1_mem_ready", mem_ready_o, 1);
    nextCycle;
    checkOutput("t1_b0_valid", load_op_valid_o, 4'hF);
    checkOutput("t1_b0_addr", load_op_addr_o, {4{10'd5}});
    checkOutput("t1_b0_strb", load_op_strb_o, 32'hFFFF_FFFF);
    checkOutput("t1_b0_data", load_op_o, mk(64'hA0));
    checkOutput("t1_b0_id", load_id_o, {4{3'd2}});
    applyStimulus(1'b1, mk(64'hB0), 4'hF);
    nextCycle;
    checkOutput("t1_b1_valid", load_op_valid_o, 4'hF);
    checkOutput("t1_b1_addr", load_op_addr_o, {4{10'd6}});
    checkOutput("t1_b1_data", load_op_o, mk(64'hB0));
    applyStimulus(1'b0, '0, 4'hF);
    checkOutput("t1_drain_mem_ready", mem_ready_o, 0);
    checkOutput("t1_drain_no_done", done_o, 0);
    nextCycle;
    checkOutput("t1_done", done_o, 1);
    checkOutput("t1_done_id", done_id_o, 3'd2);
    checkOutput("t1_idle_valid", load_op_valid_o, 0);
    checkOutput("t1_idle_cmd_ready", cmd_ready_o, 1);
    nextCycle;
    checkOutput("t1_done_pulse_end", done_o, 0);
    checkOutput("t1_done_id_held", done_id_o, 3'd2);

    // 20 bytes: lanes 0,1 full, lane 2 half, lane 3 empty
    $display("[TB] partial beat");
    issueCmd(3'd3, 10'd100, 16'd20);
    nextCycle;
    cmd_valid_i = 1'b0;
    applyStimulus(1'b1, mk(64'hC0), 4'hF);
    nextCycle;
    checkOutput("t2_valid", load_op_valid_o, 4'b0111);
    checkOutput("t2_strb", load_op_strb_o, {8'h00, 8'h0F, 8'hFF, 8'hFF});
    checkOutput("t2_cmd_ready_drain", cmd_ready_o, 0);
    applyStimulus(1'b1, mk(64'hC8), 4'hF);
    checkOutput("t2_drain_ignores_mem", mem_ready_o, 0);
    nextCycle;
    checkOutput("t2_valid_idle", load_op_valid_o, 0);
    checkOutput("t2_done", done_o, 1);
    checkOutput("t2_done_id", done_id_o, 3'd3);
    checkOutput("t2_cmd_ready", cmd_ready_o, 1);
    checkOutput("t2_data_kept", load_op_o, mk(64'hC0));
    applyStimulus(1'b0, '0, 4'hF);

    // 96 bytes with lane 2 stalled for three cycles after the first beat
    $display("[TB] lane 2 stall");
    issueCmd(3'd4, 10'd200, 16'd96);
    nextCycle;
    cmd_valid_i = 1'b0;
    applyStimulus(1'b1, mk(64'hD00), 4'hF);
    nextCycle;
    checkOutput("t3_b0_valid", load_op_valid_o, 4'hF);
    checkOutput("t3_b0_addr", load_op_addr_o, {4{10'd200}});
    applyStimulus(1'b1, mk(64'hD10), 4'b1011);
    checkOutput("t3_stall1_mem_ready", mem_ready_o, 0);
    nextCycle;
    checkOutput("t3_stall2_valid", load_op_valid_o, 4'b0100);
    checkOutput("t3_stall2_lane2_data", load_op_o[128 +: 64], 64'hD02);
    checkOutput("t3_stall2_lane2_addr", load_op_addr_o[20 +: 10], 10'd200);
    checkOutput("t3_stall2_mem_ready", mem_ready_o, 0);
    nextCycle;
    checkOutput("t3_stall3_valid", load_op_valid_o, 4'b0100);
    checkOutput("t3_stall3_lane2_data", load_op_o[128 +: 64], 64'hD02);
    checkOutput("t3_stall3_mem_ready", mem_ready_o, 0);
    applyStimulus(1'b1, mk(64'hD10), 4'hF);
    checkOutput("t3_release_mem_ready", mem_ready_o, 1);
    nextCycle;
    checkOutput("t3_b1_valid", load_op_valid_o, 4'hF);
    checkOutput("t3_b1_data", load_op_o, mk(64'hD10));
    checkOutput("t3_b1_addr", load_op_addr_o, {4{10'd201}});
    applyStimulus(1'b1, mk(64'hD20), 4'hF);
    nextCycle;
    checkOutput("t3_b2_valid", load_op_valid_o, 4'hF);
    checkOutput("t3_b2_data", load_op_o, mk(64'hD20));
    checkOutput("t3_b2_addr", load_op_addr_o, {4{10'd202}});
    applyStimulus(1'b0, '0, 4'hF);
    nextCycle;
    checkOutput("t3_done", done_o, 1);
    checkOutput("t3_done_id", done_id_o, 3'd4);
    checkOutput("t3_idle_valid", load_op_valid_o, 0);
    nextCycle;
    checkOutput("t3_done_pulse_end", done_o, 0);

    // Zero-byte command completes without touching the lanes
    $display("[TB] zero-byte command");
    issueCmd(3'd7, 10'd0, 16'd0);
    nextCycle;
    checkOutput("t4_done", done_o, 1);
    checkOutput("t4_done_id", done_id_o, 3'd7);
    checkOutput("t4_valid", load_op_valid_o, 0);
    checkOutput("t4_cmd_ready", cmd_ready_o, 1);

    // Next command accepted while done is high; address wraps 1023 -> 0
    $display("[TB] address wrap");
    issueCmd(3'd5, 10'd1023, 16'd64);
    nextCycle;
    cmd_valid_i = 1'b0;
    checkOutput("t5_done_cleared", done_o, 0);
    checkOutput("t5_cmd_ready_run", cmd_ready_o, 0);
    applyStimulus(1'b1, mk(64'hF0), 4'hF);
    nextCycle;
    checkOutput("t5_b0_addr", load_op_addr_o, {4{10'd1023}});
    applyStimulus(1'b1, mk(64'hF8), 4'hF);
    nextCycle;
    checkOutput("t5_b1_addr", load_op_addr_o, {4{10'd0}});
    checkOutput("t5_b1_id", load_id_o, {4{3'd5}});
    applyStimulus(1'b0, '0, 4'hF);
    nextCycle;
    checkOutput("t5_done", done_o, 1);
    checkOutput("t5_done_id", done_id_o, 3'd5);

    // Reset mid-RUN with two operands still buffered
    $display("[TB] reset mid-run");
    issueCmd(3'd6, 10'd50, 16'd48);
    nextCycle;
    cmd_valid_i = 1'b0;
    applyStimulus(1'b1, mk(64'h10), 4'hF);
    nextCycle;
    checkOutput("t6_b0_valid", load_op_valid_o, 4'hF);
    applyStimulus(1'b1, mk(64'h20), 4'b0011);
    checkOutput("t6_blocked_mem_ready", mem_ready_o, 0);
    nextCycle;
    checkOutput("t6_two_valid", load_op_valid_o, 4'b1100);
    checkOutput("t6_run_cmd_ready", cmd_ready_o, 0);
    rst_i = 1'b1;
    applyStimulus(1'b1, mk(64'h20), 4'b0000);
    nextCycle;
    rst_i = 1'b0;
    #1;
    checkOutput("t6_rst_valid", load_op_valid_o, 0);
    checkOutput("t6_rst_cmd_ready", cmd_ready_o, 1);
    checkOutput("t6_rst_no_done", done_o, 0);
    checkOutput("t6_rst_data", load_op_o, 0);
    checkOutput("t6_rst_strb", load_op_strb_o, 0);
    checkOutput("t6_rst_addr", load_op_addr_o, 0);
    checkOutput("t6_rst_done_id", done_id_o, 0);
    checkOutput("t6_idle_ignores_mem", mem_ready_o, 0);
    nextCycle;
    checkOutput("t6_after_no_done", done_o, 0);
    checkOutput("t6_after_valid", load_op_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
